// File: rtl/pipelined_carry_chain_adder.sv
// Pipelined carry-chain final adder: a new prop/gen vector resolves SEG_BITS bits per stage, for STAGES = ceil(WIDTH/SEG_BITS).
// Latency STAGES cycles, one operand per cycle; every stage stalls when out_valid && !out_ready. `define CARRY_CUT_EN adds approx_en.
module pipelined_carry_chain_adder #(
    parameter int WIDTH    = 50,
    parameter int SEG_BITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] prop,
    input  logic [WIDTH-1:0] gen,
    input  logic             cin,
`ifdef CARRY_CUT_EN
    input  logic             approx_en,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STAGES = (WIDTH + SEG_BITS - 1) / SEG_BITS;

    logic [STAGES-1:0]            vld_q, vld_d;
    logic [STAGES-1:0]            cry_q, cry_d;
    logic [STAGES-1:0]            apx_q, apx_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
    logic [STAGES-1:0][WIDTH-1:0] prop_q, prop_d;
    logic [STAGES-1:0][WIDTH-1:0] gen_q, gen_d;

    logic advance;
    logic approx_in;

`ifdef CARRY_CUT_EN
    assign approx_in = approx_en;
`else
    assign approx_in = 1'b0;
`endif

    assign advance  = out_ready || !vld_q[STAGES-1];
    assign in_ready = advance;

    always_comb begin : stage_next
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        logic             a;
        int               kp;
        vld_d  = vld_q;
        cry_d  = cry_q;
        apx_d  = apx_q;
        sum_d  = sum_q;
        prop_d = prop_q;
        gen_d  = gen_q;
        for (int k = 0; k < STAGES; k++) begin
            kp = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                p = prop;
                g = gen;
                s = '0;
                c = cin;
                v = in_valid;
                a = approx_in;
            end else begin
                p = prop_q[kp];
                g = gen_q[kp];
                s = sum_q[kp];
                c = cry_q[kp];
                v = vld_q[kp];
                a = apx_q[kp];
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= k * SEG_BITS && i < (k + 1) * SEG_BITS) begin
                    s[i] = p[i] ^ c;
                    c    = p[i] ? c : g[i];
                end
            end
            // Cutting the stored carry both isolates the next segment and zeroes cout.
            if (a) begin
                c = 1'b0;
            end
            if (advance) begin
                vld_d[k] = v;
                // The output stage only reloads on a real result so sum/cout never show bubble data.
                if (v || k < STAGES - 1) begin
                    sum_d[k]  = s;
                    prop_d[k] = p;
                    gen_d[k]  = g;
                    cry_d[k]  = c;
                    apx_d[k]  = a;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            cry_q  <= '0;
            apx_q  <= '0;
            sum_q  <= '0;
            prop_q <= '0;
            gen_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            cry_q  <= cry_d;
            apx_q  <= apx_d;
            sum_q  <= sum_d;
            prop_q <= prop_d;
            gen_q  <= gen_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = cry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_carry_chain_adder.sv
// Scoreboard bench for pipelined_carry_chain_adder (WIDTH=50, SEG_BITS=16, four stages).
`timescale 1ns/1ps
module tb_pipelined_carry_chain_adder;

    localparam int WIDTH  = 50;
    localparam int SEG    = 16;
    localparam int STAGES = 4;

    typedef struct {
        logic [WIDTH:0] res;
        int             acc;
        bit             lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] gen;
    logic             cin;
    logic             approx_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    bit         chk_lat = 1'b0;
    bit         stall_mode = 1'b0;
    bit         hold_q = 1'b0;
    logic [WIDTH:0] held_q = '0;

    always #5 clk = ~clk;

    pipelined_carry_chain_adder #(.WIDTH(WIDTH), .SEG_BITS(SEG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .prop(prop), .gen(gen), .cin(cin),
`ifdef CARRY_CUT_EN
        .approx_en(approx_en),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference: bit-serial carry mux chain; approx mode restarts the carry at each segment.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g,
                                               input logic ci, input logic ap);
        logic [WIDTH-1:0] s;
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ap && i != 0 && (i % SEG) == 0) c = 1'b0;
            s[i] = p[i] ^ c;
            c    = p[i] ? c : g[i];
        end
        if (ap) c = 1'b0;
        return {c, s};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_q <= 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (hold_q) chk("stall_hold", 64'({cout, sum}), 64'(held_q));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("result", 64'({cout, sum}), 64'(e.res));
                    if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
                end
            end
            if (in_valid && in_ready) begin
                e.res = ref_add(prop, gen, cin, approx_en);
                e.acc = cyc;
                e.lat = chk_lat;
                q.push_back(e);
            end
            hold_q <= out_valid && !out_ready;
            held_q <= {cout, sum};
        end
    end

    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g, input logic c, input logic ap);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        prop      = p;
        gen       = g;
        cin       = c;
        approx_en = ap;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
        @(negedge clk);
    endtask

    task automatic send_rand();
        logic [63:0] r1;
        logic [63:0] r2;
        logic [WIDTH-1:0] p;
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        p  = r1[WIDTH-1:0];
        send(p, r2[WIDTH-1:0] & ~p, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; prop = '0; gen = '0; cin = 1'b0;
        approx_en = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #3 rst_n = 1'b1;

        chk_lat = 1'b1;
        send('1, '0, 1'b1, 1'b0);
        idle();
        drain();

        send('0, 50'h2AAAAAAAAAAAA, 1'b0, 1'b0);
        send('1, '0, 1'b0, 1'b0);
        idle();
        drain();

        for (int i = 0; i < 20; i++) send_rand();
        idle();
        drain();

        chk_lat = 1'b0;
        stall_mode = 1'b1;
        for (int i = 0; i < 20; i++) send_rand();
        idle();
        drain();
        stall_mode = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) send_rand();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_sum", 64'(sum), 64'(0));
        chk("rst_mid_cout", 64'(cout), 64'(0));
        q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send_rand();
        idle();
        drain();

`ifdef CARRY_CUT_EN
        send('1, '0, 1'b1, 1'b1);
        send('1, '0, 1'b1, 1'b0);
        send(50'h0FFFF0000FFFF, 50'h3000000000000, 1'b1, 1'b1);
        idle();
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
